enum_mode_sequencer: RTL and testbench

Two-requester sequencer for a single shared mode register whose legal values form a sparse 32-bit enumeration. Each requester can step the mode forward or backward through the declared member order, with wrap-around, or load a raw value. Out-of-list loads are accepted and flagged. A round-robin arbiter with an optional lock serialises access. The block sits in front of any datapath configured by the mode value and gives it one coherent owner per cycle.

---
 rtl/enum_seq_pkg.sv | 74 +++++++
 rtl/enum_seq_rr_arb.sv | 93 +++++++++
 rtl/enum_mode_sequencer.sv | 139 +++++++++++++
 tb/tb_enum_mode_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enum_seq_pkg.sv
// ============================================================================
// enum_seq_pkg - mode member list, opcodes and lookup helpers (ENUM_SEQ_NAME_EN)
// Revision 1.0
// ============================================================================
`default_nettype none

package enum_seq_pkg;

    typedef enum int {
        M_A = 32'h0000_0001,
        M_B = 32'h0000_0040,
        M_C = 32'h0000_0800,
        M_D = 32'h0000_f00d
    } mode_t;

    typedef enum logic [1:0] {
        OP_NEXT = 2'd0,
        OP_PREV = 2'd1,
        OP_LOAD = 2'd2,
        OP_NOP  = 2'd3
    } op_t;

    localparam int NMEMBERS = 4;
    localparam int IDX_W    = 2;

    function automatic logic [IDX_W-1:0] mode_to_idx(input logic [31:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        case (v)
            32'(M_A): r = 2'd0;
            32'(M_B): r = 2'd1;
            32'(M_C): r = 2'd2;
            32'(M_D): r = 2'd3;
            default:  r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] idx_to_mode(input logic [IDX_W-1:0] i);
        logic [31:0] r;
        r = 32'(M_A);
        case (i)
            2'd0:    r = 32'(M_A);
            2'd1:    r = 32'(M_B);
            2'd2:    r = 32'(M_C);
            default: r = 32'(M_D);
        endcase
        return r;
    endfunction

    function automatic logic mode_is_member(input logic [31:0] v);
        return (v == 32'(M_A)) || (v == 32'(M_B)) ||
               (v == 32'(M_C)) || (v == 32'(M_D));
    endfunction

`ifdef ENUM_SEQ_NAME_EN
    // Right-aligned ASCII, zero-padded; non-members map to the empty name.
    function automatic logic [63:0] mode_to_name(input logic [31:0] v);
        logic [63:0] r;
        r = 64'h0;
        case (v)
            32'(M_A): r = 64'h0000_0000_004d_5f41;
            32'(M_B): r = 64'h0000_0000_004d_5f42;
            32'(M_C): r = 64'h0000_0000_004d_5f43;
            32'(M_D): r = 64'h0000_0000_004d_5f44;
            default:  r = 64'h0;
        endcase
        return r;
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/enum_seq_rr_arb.sv
// ============================================================================
// enum_seq_rr_arb - round-robin arbiter with owner lock, registered one-hot gnt
// Revision 1.0
// ============================================================================
`default_nettype none

module enum_seq_rr_arb #(
    parameter int NREQ  = 2,
    parameter int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  lock,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] owner
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

    arb_state_t       state_q;
    logic [NREQ-1:0]  gnt_q;
    logic [SEL_W-1:0] owner_q;
    logic [SEL_W-1:0] ptr_q;

    logic             win_vld;
    logic [SEL_W-1:0] win_idx;
    logic [SEL_W-1:0] cand;
    logic [NREQ-1:0]  win_onehot;
    logic [SEL_W-1:0] win_ptr_d;

    // Search starts at the pointer, which sits just past the last winner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = SEL_W'((int'(ptr_q) + k) % NREQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        win_onehot = NREQ'(1) << win_idx;
        win_ptr_d  = SEL_W'((int'(win_idx) + 1) % NREQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_GRANT, ST_LOCKED: begin
                    if (lock[owner_q]) begin
                        state_q <= ST_LOCKED;
                    end else if (win_vld) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= win_onehot;
                        owner_q <= win_idx;
                        ptr_q   <= win_ptr_d;
                    end else begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                    end
                end
                default: begin
                    if (win_vld) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= win_onehot;
                        owner_q <= win_idx;
                        ptr_q   <= win_ptr_d;
                    end else begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                    end
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;

endmodule

`default_nettype wire

// File: rtl/enum_mode_sequencer.sv
// ============================================================================
// enum_mode_sequencer - arbitrated shared mode register (ENUM_SEQ_NAME_EN adds mode_name)
// Revision 1.0
// ============================================================================
`default_nettype none

module enum_mode_sequencer
    import enum_seq_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int STRIDE_W = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                req,
    input  logic [NREQ-1:0][1:0]           op,
    input  logic [NREQ-1:0][STRIDE_W-1:0]  stride,
    input  logic [NREQ-1:0][31:0]          ld_val,
    input  logic [NREQ-1:0]                lock,
    output logic [NREQ-1:0]                gnt,
    output logic [NREQ-1:0]                ack,
    output logic [31:0]                    mode,
    output logic [IDX_W-1:0]               mode_idx,
    output logic                           mode_vld,
    output logic                           err
`ifdef ENUM_SEQ_NAME_EN
   ,output logic [63:0]                    mode_name
`endif
);

    localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]     arb_gnt;
    logic [SEL_W-1:0]    owner;

    enum_seq_rr_arb #(
        .NREQ  (NREQ),
        .SEL_W (SEL_W)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .lock  (lock),
        .gnt   (arb_gnt),
        .owner (owner)
    );

    logic [31:0]         mode_q,  mode_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic                vld_q,   vld_d;
    logic [NREQ-1:0]     ack_q,   ack_d;
    logic                err_q,   err_d;

    logic                fire;
    op_t                 cur_op;
    logic [STRIDE_W-1:0] cur_stride;
    logic [31:0]         cur_val;
    logic [IDX_W-1:0]    step;

    // An op is taken only if its requester is still asserting req under gnt.
    assign fire       = |(arb_gnt & req);
    assign cur_op     = op_t'(op[owner]);
    assign cur_stride = stride[owner];
    assign cur_val    = ld_val[owner];
    assign step       = IDX_W'(((cur_stride == '0) ? 1 : int'(cur_stride)) % NMEMBERS);

    // NMEMBERS equals 2**IDX_W, so index wrap is plain modular add/subtract.
    always_comb begin
        mode_d = mode_q;
        idx_d  = idx_q;
        vld_d  = vld_q;
        ack_d  = '0;
        err_d  = 1'b0;
        if (fire) begin
            ack_d = arb_gnt;
            case (cur_op)
                OP_NEXT, OP_PREV: begin
                    if (!vld_q) begin
                        idx_d = '0;
                    end else if (cur_op == OP_NEXT) begin
                        idx_d = idx_q + step;
                    end else begin
                        idx_d = idx_q - step;
                    end
                    mode_d = idx_to_mode(idx_d);
                    vld_d  = 1'b1;
                end
                OP_LOAD: begin
                    mode_d = cur_val;
                    vld_d  = mode_is_member(cur_val);
                    idx_d  = mode_to_idx(cur_val);
                    err_d  = !mode_is_member(cur_val);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 32'(M_A);
            idx_q  <= '0;
            vld_q  <= 1'b1;
            ack_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            idx_q  <= idx_d;
            vld_q  <= vld_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
        end
    end

`ifdef ENUM_SEQ_NAME_EN
    logic [63:0] name_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            name_q <= mode_to_name(32'(M_A));
        end else begin
            name_q <= mode_to_name(mode_d);
        end
    end

    assign mode_name = name_q;
`endif

    assign gnt      = arb_gnt;
    assign ack      = ack_q;
    assign mode     = mode_q;
    assign mode_idx = idx_q;
    assign mode_vld = vld_q;
    assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_enum_mode_sequencer.sv
// ============================================================================
// tb_enum_mode_sequencer - directed self-checking bench for enum_mode_sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_enum_mode_sequencer;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req;
    logic [1:0][1:0]  op;
    logic [1:0][1:0]  stride;
    logic [1:0][31:0] ld_val;
    logic [1:0]       lock;
    logic [1:0]       gnt;
    logic [1:0]       ack;
    logic [31:0]      mode;
    logic [1:0]       mode_idx;
    logic             mode_vld;
    logic             err;
`ifdef ENUM_SEQ_NAME_EN
    logic [63:0]      mode_name;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    enum_mode_sequencer #(
        .NREQ     (2),
        .STRIDE_W (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .op       (op),
        .stride   (stride),
        .ld_val   (ld_val),
        .lock     (lock),
        .gnt      (gnt),
        .ack      (ack),
        .mode     (mode),
        .mode_idx (mode_idx),
        .mode_vld (mode_vld),
        .err      (err)
`ifdef ENUM_SEQ_NAME_EN
       ,.mode_name(mode_name)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        req    = '0;
        lock   = '0;
        op     = '0;
        stride = '0;
        ld_val = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Holds req until gnt, keeps it through the grant cycle, returns in the ack cycle.
    task automatic issue(input int r, input logic [1:0] o, input logic [1:0] s,
                         input logic [31:0] v, output bit granted);
        op[r]     = o;
        stride[r] = s;
        ld_val[r] = v;
        req[r]    = 1'b1;
        granted   = 1'b0;
        for (int i = 0; i < 8 && !granted; i++) begin
            @(posedge clk); #1;
            if (gnt[r]) granted = 1'b1;
        end
        if (granted) begin
            @(posedge clk); #1;
        end
        req[r] = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (mode !== 32'h1 || mode_vld !== 1'b1 || mode_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_mode: got mode=%h vld=%b idx=%0d want 1/1/0", mode, mode_vld, mode_idx);
        end
        n_cmp++;
        if (gnt !== 2'b00 || ack !== 2'b00 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: got gnt=%b ack=%b err=%b want 00/00/0", gnt, ack, err);
        end
`ifdef ENUM_SEQ_NAME_EN
        n_cmp++;
        if (mode_name !== 64'h0000_0000_004d_5f41) begin
            n_bad++;
            $display("FAIL reset_name: got %h want 4d5f41", mode_name);
        end
`endif
    endtask

    task automatic test_next();
        logic [31:0] exp_mode [4];
        logic [1:0]  exp_idx  [4];
        bit g;
        exp_mode = '{32'h40, 32'h800, 32'hf00d, 32'h1};
        exp_idx  = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            issue(0, 2'd0, 2'd1, 32'h0, g);
            n_cmp++;
            if (!g) begin
                n_bad++;
                $display("FAIL next_grant[%0d]: got no gnt want gnt[0]", i);
            end
            n_cmp++;
            if (ack !== 2'b01 || mode !== exp_mode[i] || mode_idx !== exp_idx[i] || mode_vld !== 1'b1) begin
                n_bad++;
                $display("FAIL next_step[%0d]: got ack=%b mode=%h idx=%0d want 01/%h/%0d",
                         i, ack, mode, mode_idx, exp_mode[i], exp_idx[i]);
            end
            idle(1);
            n_cmp++;
            if (ack !== 2'b00) begin
                n_bad++;
                $display("FAIL next_ack_pulse[%0d]: got ack=%b want 00", i, ack);
            end
            idle(1);
        end
    endtask

    task automatic test_stride_zero();
        bit g;
        issue(0, 2'd0, 2'd0, 32'h0, g);
        n_cmp++;
        if (!g || mode !== 32'h40 || mode_idx !== 2'd1) begin
            n_bad++;
            $display("FAIL stride0: got g=%0d mode=%h idx=%0d want 1/40/1", g, mode, mode_idx);
        end
        idle(2);
        issue(1, 2'd0, 2'd3, 32'h0, g);
        n_cmp++;
        if (!g || ack !== 2'b10 || mode !== 32'h1 || mode_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL next_wrap3: got g=%0d ack=%b mode=%h idx=%0d want 1/10/1/0", g, ack, mode, mode_idx);
        end
        idle(2);
    endtask

    task automatic test_prev();
        bit g;
        issue(1, 2'd1, 2'd2, 32'h0, g);
        n_cmp++;
        if (!g || ack !== 2'b10 || mode !== 32'h800 || mode_idx !== 2'd2 || mode_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL prev2: got g=%0d ack=%b mode=%h idx=%0d want 1/10/800/2", g, ack, mode, mode_idx);
        end
        idle(2);
    endtask

    task automatic test_load();
        bit g;
        issue(0, 2'd2, 2'd0, 32'h11, g);
        n_cmp++;
        if (!g || mode !== 32'h11 || mode_vld !== 1'b0 || mode_idx !== 2'd0 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL load_nonmember: got mode=%h vld=%b idx=%0d err=%b want 11/0/0/1",
                     mode, mode_vld, mode_idx, err);
        end
`ifdef ENUM_SEQ_NAME_EN
        n_cmp++;
        if (mode_name !== 64'h0) begin
            n_bad++;
            $display("FAIL load_name: got %h want 0", mode_name);
        end
`endif
        idle(1);
        n_cmp++;
        if (err !== 1'b0 || mode !== 32'h11) begin
            n_bad++;
            $display("FAIL err_pulse: got err=%b mode=%h want 0/11", err, mode);
        end
        idle(1);
        issue(0, 2'd0, 2'd2, 32'h0, g);
        n_cmp++;
        if (!g || mode !== 32'h1 || mode_vld !== 1'b1 || mode_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL next_from_invalid: got mode=%h vld=%b idx=%0d want 1/1/0", mode, mode_vld, mode_idx);
        end
        idle(2);
        issue(1, 2'd2, 2'd0, 32'hf00d, g);
        n_cmp++;
        if (!g || mode !== 32'hf00d || mode_vld !== 1'b1 || mode_idx !== 2'd3 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL load_member: got mode=%h vld=%b idx=%0d err=%b want f00d/1/3/0",
                     mode, mode_vld, mode_idx, err);
        end
`ifdef ENUM_SEQ_NAME_EN
        n_cmp++;
        if (mode_name !== 64'h0000_0000_004d_5f44) begin
            n_bad++;
            $display("FAIL load_member_name: got %h want 4d5f44", mode_name);
        end
`endif
        idle(2);
        issue(1, 2'd1, 2'd3, 32'h0, g);
        n_cmp++;
        if (!g || mode !== 32'h1 || mode_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL prev3: got mode=%h idx=%0d want 1/0", mode, mode_idx);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g [4];
        logic [1:0] prev_g;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        apply_reset();
        op  = {2'd3, 2'd3};
        req = 2'b11;
        prev_g = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (gnt !== exp_g[i] || ack !== prev_g) begin
                n_bad++;
                $display("FAIL rr_alternate[%0d]: got gnt=%b ack=%b want %b/%b", i, gnt, ack, exp_g[i], prev_g);
            end
            prev_g = exp_g[i];
        end
        lock = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (gnt !== 2'b10 || ack !== 2'b10) begin
                n_bad++;
                $display("FAIL lock_hold[%0d]: got gnt=%b ack=%b want 10/10", i, gnt, ack);
            end
        end
        lock = 2'b00;
        @(posedge clk); #1;
        n_cmp++;
        if (gnt !== 2'b01 || ack !== 2'b10) begin
            n_bad++;
            $display("FAIL lock_release: got gnt=%b ack=%b want 01/10", gnt, ack);
        end
        req = 2'b00;
        idle(3);
        n_cmp++;
        if (gnt !== 2'b00 || mode !== 32'h1) begin
            n_bad++;
            $display("FAIL nop_idle: got gnt=%b mode=%h want 00/1", gnt, mode);
        end
    endtask

    task automatic test_reset_midop();
        bit g;
        issue(0, 2'd2, 2'd0, 32'h800, g);
        n_cmp++;
        if (!g || mode !== 32'h800) begin
            n_bad++;
            $display("FAIL midop_setup: got mode=%h want 800", mode);
        end
        idle(2);
        op[0]     = 2'd0;
        stride[0] = 2'd1;
        req[0]    = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_bad++;
            $display("FAIL midop_grant: got gnt=%b want 01", gnt);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 2'b00 || mode !== 32'h1) begin
            n_bad++;
            $display("FAIL midop_async: got gnt=%b mode=%h want 00/1", gnt, mode);
        end
        @(posedge clk); #1;
        req   = 2'b00;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ack !== 2'b00 || err !== 1'b0 || mode !== 32'h1 || mode_vld !== 1'b1) begin
                n_bad++;
                $display("FAIL midop_after[%0d]: got ack=%b err=%b mode=%h vld=%b want 00/0/1/1",
                         i, ack, err, mode, mode_vld);
            end
        end
    endtask

    initial begin
        test_reset();
        test_next();
        test_stride_zero();
        test_prev();
        test_load();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
